decimation_2x_scheduler: RTL and testbench

//  Frame-level sequencer for the 2x2-block downscale engine.
//  - Walks a source frame in 2x2 block order and streams each block's 4 pixels to the engine.
//  - Waits for the engine result, then writes that result to the destination frame.
//  - Sits between the frame memory read/write ports and one 2x2 decimation engine.

---
 rtl/decimation_2x_scheduler_if.sv | 33 +++
 rtl/decimation_2x_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_decimation_2x_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decimation_2x_scheduler_if.sv
// Frame-memory and engine bus for the 2x2 decimation scheduler.
// Master side is the scheduler; slave side is memory plus engine.
interface decimation_2x_scheduler_if #(
  parameter int ADDR_W = 15
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              eng_start;
  logic [7:0]        eng_pixel;
  logic              eng_valid;
  logic              eng_done;
  logic [7:0]        eng_result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output eng_start, eng_pixel, eng_valid,
    input  eng_done, eng_result,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  eng_start, eng_pixel, eng_valid,
    output eng_done, eng_result,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/decimation_2x_scheduler.sv
// Walks a frame in 2x2 blocks, feeds each block to the engine
// and writes the engine result to the half-size destination frame.
module decimation_2x_scheduler #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int ADDR_W   = 15,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              error,
  decimation_2x_scheduler_if.master bus
);

  localparam int BW = IMG_W / 2;
  localparam int BH = IMG_H / 2;
  localparam int XW = $clog2(BW + 1);
  localparam int YW = $clog2(BH + 1);
  localparam int TW = $clog2(WAIT_MAX + 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(2 * IMG_W);

  typedef enum logic [2:0] {
    S_IDLE, S_BLK, S_FEED, S_WAIT, S_WRITE, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [XW-1:0]     bx_q, bx_d;
  logic [YW-1:0]     by_q, by_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              error_q, error_d;

  logic              x_last;
  logic              last_blk;
  logic              timeout;
  logic [1:0]        elem;
  logic [ADDR_W-1:0] rd_addr_c;

  assign x_last   = (bx_q == XW'(BW - 1));
  assign last_blk = x_last && (by_q == YW'(BH - 1));
  assign timeout  = (wait_q == TW'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      wait_q    <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      wptr_q    <= '0;
      wr_data_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wait_q    <= wait_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      col_q     <= col_d;
      row_q     <= row_d;
      wptr_q    <= wptr_d;
      wr_data_q <= wr_data_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wait_d    = wait_q;
    bx_d      = bx_q;
    by_d      = by_q;
    col_d     = col_q;
    row_d     = row_q;
    wptr_d    = wptr_q;
    wr_data_d = wr_data_q;
    error_d   = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BLK;
          row_d   = src_base;
          col_d   = '0;
          bx_d    = '0;
          by_d    = '0;
          wptr_d  = dst_base;
          error_d = 1'b0;
        end
      end
      S_BLK: begin
        state_d = S_FEED;
        k_d     = '0;
        wait_d  = '0;
      end
      S_FEED: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q + TW'(1);
        if (bus.eng_done) begin
          state_d   = S_WRITE;
          wr_data_d = bus.eng_result;
        end else if (timeout) begin
          state_d = S_FINISH;
          error_d = 1'b1;
        end
      end
      S_WRITE: begin
        wptr_d  = wptr_q + ADDR_W'(1);
        state_d = last_blk ? S_FINISH : S_BLK;
        // Row base advances by two source rows per block row.
        if (x_last) begin
          bx_d  = '0;
          col_d = '0;
          by_d  = by_q + YW'(1);
          row_d = row_q + ROW_STEP2;
        end else begin
          bx_d  = bx_q + XW'(1);
          col_d = col_q + ADDR_W'(2);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Element 0 is read in BLK; FEED k fetches element k+1.
  assign elem = (state_q == S_FEED) ? k_q + 2'd1 : 2'd0;
  assign rd_addr_c = row_q + col_q + (elem[1] ? ROW_STEP : '0)
                   + ADDR_W'(elem[0]);

  always_comb begin
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.eng_start = 1'b0;
    bus.eng_pixel = '0;
    bus.eng_valid = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = wr_data_q;
    busy          = 1'b0;
    done          = 1'b0;
    error         = error_q;
    unique case (state_q)
      S_BLK: begin
        busy          = 1'b1;
        bus.eng_start = 1'b1;
        bus.rd_en     = 1'b1;
        bus.rd_addr   = rd_addr_c;
      end
      S_FEED: begin
        busy          = 1'b1;
        bus.eng_valid = 1'b1;
        bus.eng_pixel = bus.rd_data;
        if (k_q != 2'd3) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = rd_addr_c;
        end
      end
      S_WAIT: busy = 1'b1;
      S_WRITE: begin
        busy        = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = wptr_q;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decimation_2x_scheduler.sv
// Directed bench: 4x4 and 5x3 frames with memory and engine models.
// Engine returns the top-left pixel one cycle after the fourth pixel.
module tb_decimation_2x_scheduler;

  typedef struct {
    int          blk;
    logic [14:0] rd[4];
    logic [14:0] wa;
    logic [7:0]  wd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [14:0] src0 = '0, dst0 = '0, src1 = '0, dst1 = '0;
  logic busy0, done0, error0, busy1, done1, error1;
  logic hold0 = 1'b0, inj0 = 1'b0;
  logic dm0 = 1'b0, dm1 = 1'b0;
  logic [7:0] tl0 = '0, tl1 = '0, res0 = '0, res1 = '0;
  int cnt0 = 0, cnt1 = 0;
  int checks = 0, errors = 0;

  logic [14:0] rl0[$], rl1[$], wa0[$], wa1[$];
  logic [7:0]  wd0[$], wd1[$];
  int          vc0[$];

  vec_t vecs[4];

  decimation_2x_scheduler_if #(.ADDR_W(15)) if0 ();
  decimation_2x_scheduler_if #(.ADDR_W(15)) if1 ();

  decimation_2x_scheduler #(.IMG_W(4), .IMG_H(4)) u0 (
    .clk(clk), .reset_n(rst_n), .start(start0),
    .src_base(src0), .dst_base(dst0),
    .busy(busy0), .done(done0), .error(error0), .bus(if0)
  );

  decimation_2x_scheduler #(.IMG_W(5), .IMG_H(3)) u1 (
    .clk(clk), .reset_n(rst_n), .start(start1),
    .src_base(src1), .dst_base(dst1),
    .busy(busy1), .done(done1), .error(error1), .bus(if1)
  );

  always #5 clk = ~clk;

  assign if0.eng_done   = dm0 | inj0;
  assign if0.eng_result = res0;
  assign if1.eng_done   = dm1;
  assign if1.eng_result = res1;

  // Memory holds mem[a] = a; read data one cycle after rd_en.
  always @(posedge clk) begin
    if0.rd_data <= if0.rd_en ? if0.rd_addr[7:0] : 8'h00;
    if1.rd_data <= if1.rd_en ? if1.rd_addr[7:0] : 8'h00;
    if (if0.eng_start) cnt0 <= 0;
    else if (if0.eng_valid) begin
      if (cnt0 == 0) tl0 <= if0.eng_pixel;
      cnt0 <= cnt0 + 1;
    end
    dm0 <= if0.eng_valid && cnt0 == 3 && !hold0;
    if (if0.eng_valid && cnt0 == 3) res0 <= tl0;
    if (if1.eng_start) cnt1 <= 0;
    else if (if1.eng_valid) begin
      if (cnt1 == 0) tl1 <= if1.eng_pixel;
      cnt1 <= cnt1 + 1;
    end
    dm1 <= if1.eng_valid && cnt1 == 3;
    if (if1.eng_valid && cnt1 == 3) res1 <= tl1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.rd_en) rl0.push_back(if0.rd_addr);
      if (if1.rd_en) rl1.push_back(if1.rd_addr);
      if (if0.wr_en) begin
        wa0.push_back(if0.wr_addr);
        wd0.push_back(if0.wr_data);
      end
      if (if1.wr_en) begin
        wa1.push_back(if1.wr_addr);
        wd1.push_back(if1.wr_data);
      end
      if (if0.eng_start) vc0.push_back(0);
      if (if0.eng_valid && vc0.size() > 0)
        vc0[vc0.size()-1] = vc0[vc0.size()-1] + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic go0();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int bound,
                           output int n);
    n = 0;
    while (!(which ? done1 : done0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!(which ? done1 : done0)) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_writes0(input string nm, input int b);
    chk({nm, "_wcount"}, wa0.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_waddr"}, wa0[b+i], vecs[i].wa);
      chk({nm, "_wdata"}, wd0[b+i], vecs[i].wd);
    end
  endtask

  initial begin
    int n, wb, rb, vb, bad, seen;
    vecs[0] = '{blk: 0, rd: '{0, 1, 4, 5},     wa: 64, wd: 0};
    vecs[1] = '{blk: 1, rd: '{2, 3, 6, 7},     wa: 65, wd: 2};
    vecs[2] = '{blk: 2, rd: '{8, 9, 12, 13},   wa: 66, wd: 8};
    vecs[3] = '{blk: 3, rd: '{10, 11, 14, 15}, wa: 67, wd: 10};

    repeat (2) @(negedge clk);
    chk("reset_u0", {busy0, done0, error0, if0.rd_en, if0.rd_addr,
        if0.eng_start, if0.eng_valid, if0.eng_pixel, if0.wr_en,
        if0.wr_addr, if0.wr_data}, 0);
    chk("reset_u1", {busy1, done1, error1, if1.rd_en, if1.wr_en,
        if1.wr_data, if1.eng_valid}, 0);
    rst_n = 1'b1;
    dst0 = 15'd64;
    dst1 = 15'd64;

    // Plain 4x4 frame
    wb = wa0.size(); rb = rl0.size(); vb = vc0.size();
    go0();
    chk("first_busy", busy0, 1);
    chk("first_eng_start", if0.eng_start, 1);
    chk("first_rd_addr", if0.rd_addr, 0);
    wait_done(0, 200, n);
    chk("frame_cycles", n, 28);
    chk("busy_with_done", busy0, 0);
    @(negedge clk);
    chk("done_one_cycle", done0, 0);
    chk("rd_count", rl0.size() - rb, 16);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("rd_b%0d_e%0d", vecs[i].blk, j),
            rl0[rb+4*i+j], vecs[i].rd[j]);
      chk($sformatf("valid_b%0d", vecs[i].blk), vc0[vb+i], 4);
    end
    chk_writes0("frame", wb);

    // Odd 5x3 frame
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1, 200, n);
    chk("odd_cycles", n, 14);
    @(negedge clk);
    chk("odd_wcount", wa1.size(), 2);
    chk("odd_w0", {wa1[0], wd1[0]}, {15'd64, 8'd0});
    chk("odd_w1", {wa1[1], wd1[1]}, {15'd65, 8'd2});
    chk("odd_rcount", rl1.size(), 8);
    bad = 0;
    foreach (rl1[i]) if (rl1[i] % 5 == 4 || rl1[i] >= 10) bad++;
    chk("odd_bad_reads", bad, 0);

    // Engine timeout
    hold0 = 1'b1;
    wb = wa0.size();
    go0();
    wait_done(0, 100, n);
    chk("to_cycles", n, 20);
    chk("to_error", error0, 1);
    chk("to_done", done0, 1);
    chk("to_no_write", wa0.size() - wb, 0);
    @(negedge clk);
    chk("to_error_sticky", error0, 1);
    hold0 = 1'b0;
    wb = wa0.size();
    go0();
    chk("to_error_cleared", error0, 0);
    wait_done(0, 200, n);
    chk("after_to_cycles", n, 28);
    @(negedge clk);
    chk_writes0("after_to", wb);

    // Reset during FEED of block 1
    wb = wa0.size();
    go0();
    seen = if0.eng_start ? 1 : 0;
    n = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (if0.eng_start) seen++;
    end
    chk("blk1_start_cycle", n, 7);
    @(negedge clk);
    chk("in_feed", if0.eng_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs", {busy0, done0, error0, if0.rd_en, if0.rd_addr,
        if0.eng_start, if0.eng_valid, if0.eng_pixel, if0.wr_en,
        if0.wr_addr, if0.wr_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_aborted_writes", wa0.size() - wb, 1);
    chk("rst_idle", busy0, 0);
    wb = wa0.size();
    go0();
    wait_done(0, 200, n);
    chk("rerun_cycles", n, 28);
    @(negedge clk);
    chk_writes0("rerun", wb);

    // start while busy and eng_done during FEED are ignored
    wb = wa0.size();
    go0();
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    src0 = 15'd100;
    inj0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    src0 = 15'd0;
    inj0 = 1'b0;
    wait_done(0, 200, n);
    chk("ignore_cycles", n, 25);
    @(negedge clk);
    chk_writes0("ignore", wb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
